// File: rtl/trigger_handling_v3_pkg.sv
// trigger_defs_v3: shared defaults for the ATRI L4 -> T1 trigger combiner.
//   DEF_DELAY_BITS   : per-channel delay width (max delay 2^N-1 clocks)
//   DEF_PRETRG_BITS  : per-channel pretrigger width
//   DEF_OFFSET_BITS  : width of the reported readout block offset
//   DEF_HOLDOFF_BITS : width of the post-T1 holdoff count
//   INTERNAL_DELAY   : readout blocks spent inside the trigger path itself
//   DEF_BASE_OFFSET  : constant added to the block offset (includes INTERNAL_DELAY)
package trigger_defs_v3;
  localparam int DEF_DELAY_BITS   = 5;
  localparam int DEF_PRETRG_BITS  = 6;
  localparam int DEF_OFFSET_BITS  = 9;
  localparam int DEF_HOLDOFF_BITS = 8;
  localparam int INTERNAL_DELAY   = 2;
  localparam int DEF_BASE_OFFSET  = INTERNAL_DELAY + 2;
endpackage

// File: rtl/par_compare_tree.sv
// par_compare_tree: registered unsigned maximum of N packed fields, 2-cycle latency.
//   clk_i, rst_n_i : clock, asynchronous active-low reset
//   data_i         : N fields of W bits, field i at [i*W +: W]
//   max_o          : maximum field, valid two clocks after data_i settles
module par_compare_tree #(
  parameter int N = 4,
  parameter int W = 6
) (
  input  logic         clk_i,
  input  logic         rst_n_i,
  input  logic [N*W-1:0] data_i,
  output logic [W-1:0] max_o
);
  localparam int GROUPS = (N + 3) / 4;

  // Zero padding to whole groups of four cannot change an unsigned maximum.
  logic [GROUPS*4*W-1:0] w_pad;
  logic [W-1:0]          w_grp [GROUPS];
  logic [W-1:0]          r_grp [GROUPS];
  logic [W-1:0]          w_max;
  logic [W-1:0]          r_max;

  always_comb begin
    w_pad = '0;
    w_pad[N*W-1:0] = data_i;
  end

  // Stage 1: maximum within each group of four.
  for (genvar gi = 0; gi < GROUPS; gi++) begin : g_grp
    logic [W-1:0] w_m;
    always_comb begin
      w_m = '0;
      for (int k = 0; k < 4; k++)
        if (w_pad[(gi*4+k)*W +: W] > w_m) w_m = w_pad[(gi*4+k)*W +: W];
    end
    assign w_grp[gi] = w_m;
  end

  // Stage 2: maximum over the group results.
  always_comb begin
    w_max = '0;
    for (int g = 0; g < GROUPS; g++)
      if (r_grp[g] > w_max) w_max = r_grp[g];
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_grp <= '{default: '0};
      r_max <= '0;
    end else begin
      r_grp <= w_grp;
      r_max <= w_max;
    end
  end

  assign max_o = r_max;
endmodule

// File: rtl/var_delay_line.sv
// var_delay_line: reset-clearable delay line with a per-clock programmable tap.
//   clk_i, rst_n_i : clock, asynchronous active-low reset (clears every tap)
//   delay_i        : delay in clocks, 0 = combinational pass-through
//   data_i/data_o  : WIDTH-bit sample in / delayed sample out
module var_delay_line #(
  parameter int WIDTH     = 2,
  parameter int ADDR_BITS = 5
) (
  input  logic                 clk_i,
  input  logic                 rst_n_i,
  input  logic [ADDR_BITS-1:0] delay_i,
  input  logic [WIDTH-1:0]     data_i,
  output logic [WIDTH-1:0]     data_o
);
  localparam int DEPTH = 2 ** ADDR_BITS;

  // r_taps[k] holds data_i delayed by k+1 clocks.
  logic [WIDTH-1:0] r_taps [DEPTH];

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_taps <= '{default: '0};
    end else begin
      r_taps[0] <= data_i;
      for (int k = 1; k < DEPTH; k++) r_taps[k] <= r_taps[k-1];
    end
  end

  assign data_o = (delay_i == '0) ? data_i : r_taps[delay_i - 1'b1];
endmodule

// File: rtl/trigger_handling_v3.sv
// trigger_handling_v3: delays each enabled L4 trigger, aligns all channels to the
// largest pretrigger, ORs them into T1 and reports the readout block offset.
//   clk_i, rst_n_i         : clock, asynchronous active-low reset
//   pretrigger_vector_i    : per-channel pretrigger counts
//   delay_vector_i         : per-channel delays
//   l4_enable_i            : per-channel enable (gates l4_i and l4_new_i)
//   l4_i, l4_new_i         : L4 trigger pulses and new-event flags
//   T1_mask_i, holdoff_i   : global T1 mask, post-T1 suppression length
//   disable_i, disable_ce_i: IRS disable sample and its per-block enable
//   T1_o, T1_scaler_o      : masked / unmasked trigger
//   T1_offset_o            : readout offset in blocks
//   l4_matched_o, l4_new_o : channel pattern / masked new flags aligned to T1_o
//   holdoff_active_o       : holdoff counter nonzero
module trigger_handling_v3
  import trigger_defs_v3::*;
#(
  parameter int NUM_L4       = 4,
  parameter int DELAY_BITS   = DEF_DELAY_BITS,
  parameter int PRETRG_BITS  = DEF_PRETRG_BITS,
  parameter int DIS_DEPTH    = 128,
  parameter int BASE_OFFSET  = DEF_BASE_OFFSET,
  parameter int OFFSET_BITS  = DEF_OFFSET_BITS,
  parameter int HOLDOFF_BITS = DEF_HOLDOFF_BITS
) (
  input  logic                          clk_i,
  input  logic                          rst_n_i,
  input  logic [NUM_L4*PRETRG_BITS-1:0] pretrigger_vector_i,
  input  logic [NUM_L4*DELAY_BITS-1:0]  delay_vector_i,
  input  logic [NUM_L4-1:0]             l4_enable_i,
  input  logic [NUM_L4-1:0]             l4_i,
  input  logic [NUM_L4-1:0]             l4_new_i,
  input  logic                          T1_mask_i,
  input  logic [HOLDOFF_BITS-1:0]       holdoff_i,
  input  logic                          disable_i,
  input  logic                          disable_ce_i,
  output logic                          T1_o,
  output logic                          T1_scaler_o,
  output logic [OFFSET_BITS-1:0]        T1_offset_o,
  output logic [NUM_L4-1:0]             l4_matched_o,
  output logic [NUM_L4-1:0]             l4_new_o,
  output logic                          holdoff_active_o
);
  logic [NUM_L4-1:0]       w_l4_g, w_new_g;
  logic [NUM_L4-1:0]       w_al_l4, w_al_new;
  logic [PRETRG_BITS-1:0]  w_max_pt;
  logic                    w_dis_mask, w_hold_eff, w_allow, w_t1_next;

  logic                    r_scaler, r_t1;
  logic [NUM_L4-1:0]       r_match_l4, r_match_new, r_matched_out, r_new_out;
  logic [OFFSET_BITS-1:0]  r_offset;
  logic [DIS_DEPTH-1:0]    r_dis_hist;
  logic                    r_disable_hold;
  logic [HOLDOFF_BITS-1:0] r_holdoff_cnt;

  assign w_l4_g  = l4_i & l4_enable_i;
  assign w_new_g = l4_new_i & l4_enable_i;

  par_compare_tree #(.N(NUM_L4), .W(PRETRG_BITS)) u_max (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .data_i  (pretrigger_vector_i),
    .max_o   (w_max_pt)
  );

  for (genvar gi = 0; gi < NUM_L4; gi++) begin : g_ch
    logic [PRETRG_BITS-1:0] w_pt;
    logic [PRETRG_BITS-1:0] r_off;
    logic [1:0]             w_s1, w_s2;

    assign w_pt = pretrigger_vector_i[gi*PRETRG_BITS +: PRETRG_BITS];

    // max_pt lags a pretrigger change by two clocks; clamp so the offset never wraps.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i)               r_off <= '0;
      else if (w_max_pt >= w_pt)  r_off <= w_max_pt - w_pt;
      else                        r_off <= '0;
    end

    // Bit 0 carries the trigger, bit 1 the new-event flag, so both stay aligned.
    var_delay_line #(.WIDTH(2), .ADDR_BITS(DELAY_BITS)) u_dly (
      .clk_i   (clk_i),
      .rst_n_i (rst_n_i),
      .delay_i (delay_vector_i[gi*DELAY_BITS +: DELAY_BITS]),
      .data_i  ({w_new_g[gi], w_l4_g[gi]}),
      .data_o  (w_s1)
    );

    var_delay_line #(.WIDTH(2), .ADDR_BITS(PRETRG_BITS)) u_aln (
      .clk_i   (clk_i),
      .rst_n_i (rst_n_i),
      .delay_i (r_off),
      .data_i  (w_s1),
      .data_o  (w_s2)
    );

    assign w_al_l4[gi]  = w_s2[0];
    assign w_al_new[gi] = w_s2[1];
  end

  // Disable sample for the block the readout will start at.
  assign w_dis_mask = |(r_dis_hist & (DIS_DEPTH'(1) << r_offset));

  // A matched new-event flag releases the hold in the same cycle, so the
  // trigger carrying that flag is the first one let through.
  assign w_hold_eff = r_disable_hold & ~(|r_match_new);
  assign w_allow    = ~T1_mask_i & ~w_dis_mask & ~w_hold_eff & (r_holdoff_cnt == '0);
  assign w_t1_next  = r_scaler & w_allow;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_scaler       <= 1'b0;
      r_match_l4     <= '0;
      r_match_new    <= '0;
      r_t1           <= 1'b0;
      r_matched_out  <= '0;
      r_new_out      <= '0;
      r_offset       <= '0;
      r_dis_hist     <= '0;
      r_disable_hold <= 1'b0;
      r_holdoff_cnt  <= '0;
    end else begin
      r_scaler      <= |w_al_l4;
      r_match_l4    <= w_al_l4;
      r_match_new   <= w_al_new;
      r_t1          <= w_t1_next;
      r_matched_out <= r_match_l4;
      r_new_out     <= r_match_new & {NUM_L4{w_allow}};
      r_offset      <= OFFSET_BITS'(w_max_pt) + OFFSET_BITS'(BASE_OFFSET);

      if (disable_ce_i) r_dis_hist <= {r_dis_hist[DIS_DEPTH-2:0], disable_i};

      if (w_dis_mask)         r_disable_hold <= 1'b1;
      else if (|r_match_new)  r_disable_hold <= 1'b0;

      if (w_t1_next)                 r_holdoff_cnt <= holdoff_i;
      else if (r_holdoff_cnt != '0)  r_holdoff_cnt <= r_holdoff_cnt - 1'b1;
    end
  end

  assign T1_o             = r_t1;
  assign T1_scaler_o      = r_scaler;
  assign T1_offset_o      = r_offset;
  assign l4_matched_o     = r_matched_out;
  assign l4_new_o         = r_new_out;
  assign holdoff_active_o = (r_holdoff_cnt != '0);
endmodule

// File: tb/tb_trigger_handling_v3.sv
module tb_trigger_handling_v3;
  logic        clk_i = 1'b0;
  logic        rst_n_i;
  logic [23:0] pretrigger_vector_i;
  logic [19:0] delay_vector_i;
  logic [3:0]  l4_enable_i, l4_i, l4_new_i;
  logic        T1_mask_i;
  logic [7:0]  holdoff_i;
  logic        disable_i, disable_ce_i;
  logic        T1_o, T1_scaler_o, holdoff_active_o;
  logic [8:0]  T1_offset_o;
  logic [3:0]  l4_matched_o, l4_new_o;

  int total = 0;
  int bad   = 0;

  int         sc_first, sc_cnt, t1_first, t1_second, t1_cnt, ho_cnt;
  logic [3:0] m_first, m_last, n_first, n_any;

  trigger_handling_v3 dut (
    .clk_i               (clk_i),
    .rst_n_i             (rst_n_i),
    .pretrigger_vector_i (pretrigger_vector_i),
    .delay_vector_i      (delay_vector_i),
    .l4_enable_i         (l4_enable_i),
    .l4_i                (l4_i),
    .l4_new_i            (l4_new_i),
    .T1_mask_i           (T1_mask_i),
    .holdoff_i           (holdoff_i),
    .disable_i           (disable_i),
    .disable_ce_i        (disable_ce_i),
    .T1_o                (T1_o),
    .T1_scaler_o         (T1_scaler_o),
    .T1_offset_o         (T1_offset_o),
    .l4_matched_o        (l4_matched_o),
    .l4_new_o            (l4_new_o),
    .holdoff_active_o    (holdoff_active_o)
  );

  always #5 clk_i = ~clk_i;

  task check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end else begin
      $display("ok   %s: %0d", tag, got);
    end
  endtask

  task tick;
    @(posedge clk_i);
    #1;
  endtask

  // Drive a pattern in relative cycle 0 (held for the whole window if keep),
  // then record what the outputs do in cycles 1..win.
  task watch(input logic [3:0] l4p, input logic [3:0] newp, input int win, input bit keep);
    l4_i = l4p; l4_new_i = newp;
    sc_first = -1; sc_cnt = 0; t1_first = -1; t1_second = -1; t1_cnt = 0; ho_cnt = 0;
    m_first = '0; m_last = '0; n_first = '0; n_any = '0;
    for (int k = 1; k <= win; k++) begin
      tick();
      if (!keep) begin l4_i = '0; l4_new_i = '0; end
      if (T1_scaler_o) begin sc_cnt++; if (sc_first < 0) sc_first = k; end
      if (holdoff_active_o) ho_cnt++;
      n_any = n_any | l4_new_o;
      if (T1_o) begin
        t1_cnt++;
        m_last = l4_matched_o;
        if (t1_first < 0) begin t1_first = k; m_first = l4_matched_o; n_first = l4_new_o; end
        else if (t1_second < 0) t1_second = k;
      end
    end
    l4_i = '0; l4_new_i = '0;
  endtask

  initial begin
    rst_n_i = 1'b0;
    pretrigger_vector_i = '0; delay_vector_i = '0; l4_enable_i = 4'b1111;
    l4_i = '0; l4_new_i = '0; T1_mask_i = 1'b0; holdoff_i = '0;
    disable_i = 1'b0; disable_ce_i = 1'b0;
    #1;
    check_val("reset_outputs", {T1_o, T1_scaler_o, T1_offset_o, l4_matched_o, l4_new_o, holdoff_active_o}, 0);
    repeat (2) tick();
    rst_n_i = 1'b1;
    repeat (6) tick();

    // Single channel, delay 3.
    delay_vector_i = {5'd0, 5'd0, 5'd0, 5'd3};
    repeat (6) tick();
    check_val("single_offset", T1_offset_o, 4);
    watch(4'b0001, 4'b0001, 20, 1'b0);
    check_val("single_scaler_cycle", sc_first, 4);
    check_val("single_t1_cycle", t1_first, 5);
    check_val("single_t1_count", t1_cnt, 1);
    check_val("single_matched", m_first, 4'b0001);
    check_val("single_new", n_first, 4'b0001);

    // Alignment to the largest pretrigger (ch0=10, ch1=2).
    delay_vector_i = '0;
    pretrigger_vector_i = {6'd0, 6'd0, 6'd2, 6'd10};
    repeat (6) tick();
    check_val("align_offset", T1_offset_o, 14);
    watch(4'b0011, 4'b0000, 20, 1'b0);
    check_val("align_ch0_cycle", t1_first, 2);
    check_val("align_ch0_pattern", m_first, 4'b0001);
    check_val("align_ch1_cycle", t1_second, 10);
    check_val("align_ch1_pattern", m_last, 4'b0010);
    check_val("align_t1_count", t1_cnt, 2);

    // Holdoff of 5 with a continuous trigger.
    pretrigger_vector_i = '0;
    holdoff_i = 8'd5;
    repeat (6) tick();
    watch(4'b0001, 4'b0000, 20, 1'b1);
    check_val("holdoff_scaler_count", sc_cnt, 20);
    check_val("holdoff_first_t1", t1_first, 2);
    check_val("holdoff_second_t1", t1_second, 8);
    check_val("holdoff_t1_count", t1_cnt, 4);
    check_val("holdoff_active_count", ho_cnt, 16);
    holdoff_i = '0;
    repeat (10) tick();
    check_val("holdoff_drained", holdoff_active_o, 0);

    // Disable history: sample 1 pushed four more deep lands on offset 4.
    disable_ce_i = 1'b1; disable_i = 1'b1;
    tick();
    disable_i = 1'b0;
    repeat (4) tick();
    disable_ce_i = 1'b0;
    watch(4'b0001, 4'b0000, 6, 1'b0);
    check_val("dis_scaler_cycle", sc_first, 1);
    check_val("dis_t1_suppressed", t1_cnt, 0);
    disable_ce_i = 1'b1;
    tick();
    disable_ce_i = 1'b0;
    watch(4'b0001, 4'b0000, 6, 1'b0);
    check_val("dis_hold_suppressed", t1_cnt, 0);
    watch(4'b0001, 4'b0001, 6, 1'b0);
    check_val("dis_new_releases_t1", t1_first, 2);
    check_val("dis_new_out", n_first, 4'b0001);
    watch(4'b0001, 4'b0000, 6, 1'b0);
    check_val("dis_hold_cleared", t1_first, 2);

    // Enable mask and global T1 mask.
    l4_enable_i = 4'b1110;
    watch(4'b0001, 4'b0001, 6, 1'b0);
    check_val("enable_scaler_count", sc_cnt, 0);
    check_val("enable_t1_count", t1_cnt, 0);
    l4_enable_i = 4'b1111;
    T1_mask_i = 1'b1;
    watch(4'b0001, 4'b0001, 6, 1'b0);
    check_val("mask_scaler_cycle", sc_first, 1);
    check_val("mask_t1_count", t1_cnt, 0);
    check_val("mask_new_out", n_any, 0);
    check_val("mask_matched_unmasked", l4_matched_o, 0);
    T1_mask_i = 1'b0;

    // Reset while a delay-20 pulse is in flight.
    delay_vector_i = {5'd0, 5'd0, 5'd0, 5'd20};
    repeat (6) tick();
    l4_i = 4'b0001;
    tick();
    l4_i = '0;
    repeat (4) tick();
    rst_n_i = 1'b0;
    #1;
    check_val("midflight_reset_outputs", {T1_o, T1_scaler_o, T1_offset_o, l4_matched_o, l4_new_o, holdoff_active_o}, 0);
    repeat (2) tick();
    rst_n_i = 1'b1;
    watch(4'b0000, 4'b0000, 30, 1'b0);
    check_val("midflight_no_scaler", sc_cnt, 0);
    check_val("midflight_no_t1", t1_cnt, 0);
    check_val("midflight_offset_back", T1_offset_o, 4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/trigger_handling_v3.md
Name: trigger_handling_v3

Overview:
- Parametrised successor trigger combiner for the ATRI trigger path, sitting between the L4 trigger sources and the IRS readout scheduler.
- Delays each L4 trigger by its own programmable delay, then aligns all triggers to the largest pretrigger. It ORs them into T1 and reports the readout block offset.
- Over the previous generation it adds:
  - arbitrary delay, pretrigger and disable-history depths (no 32/64/96 limits);
  - a per-channel enable mask;
  - a programmable post-T1 holdoff counter;
  - a registered trigger-pattern output.

Parameters:
- NUM_L4, 4, number of L4 trigger inputs (1..16).
- DELAY_BITS, 5, width of each per-channel delay; maximum delay is 2^DELAY_BITS-1 clocks.
- PRETRG_BITS, 6, width of each pretrigger count; maximum alignment is 2^PRETRG_BITS-1 clocks.
- DIS_DEPTH, 128, disable history depth in CE samples; must be >= 2^PRETRG_BITS+BASE_OFFSET+1.
- BASE_OFFSET, 4, constant added to the block offset (includes the internal 2-block latency).
- OFFSET_BITS, 9, width of T1_offset_o.
- HOLDOFF_BITS, 8, width of the holdoff count.

Ports:
- clk_i  in  1  system clock.
- rst_n_i  in  1  asynchronous, active-low reset.
- pretrigger_vector_i  in  NUM_L4*PRETRG_BITS  concatenated pretrigger counts, channel i at [i*PRETRG_BITS +: PRETRG_BITS].
- delay_vector_i  in  NUM_L4*DELAY_BITS  concatenated delays.
- l4_enable_i  in  NUM_L4  per-channel enable.
- l4_i  in  NUM_L4  L4 trigger pulses.
- l4_new_i  in  NUM_L4  L4 new-event flags.
- T1_mask_i  in  1  global T1 mask.
- holdoff_i  in  HOLDOFF_BITS  clocks of T1 suppression after each T1_o.
- disable_i  in  1  IRS disable for the current block.
- disable_ce_i  in  1  disable sample enable, one per block.
- T1_o  out  1  masked trigger output.
- T1_scaler_o  out  1  unmasked trigger output.
- T1_offset_o  out  OFFSET_BITS  readout offset in blocks.
- l4_matched_o  out  NUM_L4  L4 pattern aligned to T1_o.
- l4_new_o  out  NUM_L4  new-event flags aligned to T1_o, masked.
- holdoff_active_o  out  1  holdoff counter nonzero.

Behaviour:
- Reset (rst_n_i low, asynchronous) clears:
  - all delay and match lines and the disable history;
  - the holdoff counter and disable_hold;
  - every output, which reads 0.
- Channel gating: l4_i[i] and l4_new_i[i] are ANDed with l4_enable_i[i] at input.
- Max pretrigger: max_pt is the unsigned maximum over all pretrigger fields. It is registered, with a 2-cycle compare pipeline.
- Match offset: off[i] = max_pt - pretrigger[i], registered, never negative.
- Delay path:
  - Stage 1 delays each gated channel by delay[i] clocks; delay 0 means pass-through.
  - Stage 2 delays it by off[i] clocks.
  - Depths are 2^DELAY_BITS and 2^PRETRG_BITS shift or circular buffers, giving exact per-clock delays.
- End-to-end latency: an l4_i[i] pulse at cycle t appears on T1_scaler_o at t + delay[i] + off[i] + 1, and on T1_o and l4_matched_o at t + delay[i] + off[i] + 2. Multi-cycle pulses are preserved in width.
- T1_offset_o is registered as max_pt + BASE_OFFSET, zero-extended to OFFSET_BITS.
- Disable history:
  - Each disable_ce_i pushes disable_i into a DIS_DEPTH history; index 0 is the newest sample.
  - dis_mask = hist[T1_offset_o].
- disable_hold is set when dis_mask=1. It is cleared when dis_mask=0 and any matched new flag is 1. Set wins over clear when both occur.
- T1_o is set in the cycle after T1_scaler_o=1 only when T1_mask_i=0, dis_mask=0, disable_hold=0 and holdoff_cnt=0.
- l4_new_o carries the same cycle and mask terms as T1_o. l4_matched_o is unmasked.
- Holdoff counter:
  - Loads holdoff_i in the cycle T1_o=1, then decrements to 0.
  - holdoff_i=0 means no holdoff.
  - A trigger coinciding with the count reaching 0 on the same edge is still suppressed; triggers pass from the next cycle.
  - holdoff does not gate T1_scaler_o.
- Configuration changes (pretrigger, delay, enable) are quasi-static.
  - Outputs are valid 4 clocks after the last change.
  - Pulses in flight during a change may be lost or duplicated; no X and no lockup.
- Disabling a channel does not flush pulses already in its delay line.

Decomposition:
- Package trigger_defs_v3 holds the default widths (DELAY_BITS, PRETRG_BITS, OFFSET_BITS, HOLDOFF_BITS), BASE_OFFSET and INTERNAL_DELAY.
- Sub-module var_delay_line (WIDTH, ADDR_BITS): a 2-bit-wide, reset-clearable, per-clock programmable delay, instantiated twice per channel.
- The max compare reuses the existing par_compare_tree.

Test Plan:
- Single channel: pretrig all 0, delay[0]=3, l4_i[0] pulse at t=10 -> T1_scaler_o=1 at t=14, T1_o and l4_matched_o=0001 at t=15, T1_offset_o=4.
- Alignment: pretrig={10,2,0,0}, delays 0, pulses on ch1 and ch0 at t=20 -> ch0 T1_o at 22, ch1 T1_o at 30, T1_offset_o=14.
- Holdoff: holdoff_i=5, l4_i[0] every cycle, all delays and pretrig 0 -> T1_o pulses separated by 6 cycles. T1_scaler_o stays high continuously, holdoff_active_o high for 5 cycles after each T1_o.
- Disable history: BASE_OFFSET=4, max_pt=0, disable_i=1 on one CE sample, then 4 more CE pushes, then trigger -> T1_o suppressed. disable_hold stays set until an l4_new_i pulse arrives, and T1_o reasserts with that pulse.
- Enable and mask: l4_enable_i=1110 with a pulse on ch0 -> no output. T1_mask_i=1 -> T1_scaler_o=1, T1_o=0, l4_new_o=0.
- Reset mid-flight: pulse with delay 20, rst_n_i low at +5 -> all outputs 0 immediately, no pulse after release.
